// File: rtl/pmc_pkg.sv
// Shared definitions for the PMC readout path: frame FSM states, frame
// constants and the word layout of the packed counter bus.
package pmc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4
    } pmc_state_t;

    localparam logic [7:0]  PMC_HEADER_BYTE = 8'hA5;
    localparam int unsigned PMC_NUM_WORDS   = 26;

    // Word positions of each PMC counter on counters_in
    localparam int unsigned PMC_W_STALL      = 0;
    localparam int unsigned PMC_W_CPI_NUM    = 1;
    localparam int unsigned PMC_W_CPI_DEN    = 2;
    localparam int unsigned PMC_W_CPI        = 3;  // 16-bit value, zero-extended
    localparam int unsigned PMC_W_ARITH      = 4;
    localparam int unsigned PMC_W_MEM_ACCESS = 5;
    localparam int unsigned PMC_W_MEM_READ   = 6;
    localparam int unsigned PMC_W_MEM_WRITE  = 7;
    localparam int unsigned PMC_W_INSN_BASE  = 8;  // first of the per-instruction counts
    localparam int unsigned PMC_W_INSN_COUNT = 18;

endpackage

// File: rtl/pmc_snapshot_reg.sv
// Snapshot bank: holds a frozen copy of all counter words and exposes
// them one byte at a time, byte index 0 = word 0 bits [7:0].
module pmc_snapshot_reg
    import pmc_pkg::*;
#(
    parameter int unsigned NUM_WORDS = PMC_NUM_WORDS,
    parameter int unsigned IDX_W     = $clog2(4 * PMC_NUM_WORDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [NUM_WORDS*32-1:0] din,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [7:0]             rd_byte
);

    localparam int unsigned NBYTES = 4 * NUM_WORDS;

    logic [NUM_WORDS*32-1:0] snap;

    // Capture the whole counter bus in a single edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap <= '0;
        end else if (load) begin
            snap <= din;
        end
    end

    // Byte-select read; indices past the last byte read as zero
    always_comb begin
        rd_byte = 8'h00;
        if (32'(rd_idx) < NBYTES) begin
            rd_byte = snap[{rd_idx, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/pmc_readout.sv
// PMC readout: snapshots the counter bus on request and streams it as a
// framed byte sequence (header, length, data, XOR checksum) over
// valid/ready. All outputs come straight from flops.
module pmc_readout
    import pmc_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = PMC_NUM_WORDS,
    parameter logic [7:0]  HEADER_BYTE = PMC_HEADER_BYTE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    snapshot_req,
    input  logic [NUM_WORDS*32-1:0] counters_in,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_count
);

    localparam int unsigned     NBYTES   = 4 * NUM_WORDS;
    localparam int unsigned     IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [7:0]      LEN_BYTE = 8'(NUM_WORDS);

    pmc_state_t       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [7:0]       chk, chk_nxt;
    logic             tx_valid_nxt;
    logic [7:0]       tx_data_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [15:0]      count_nxt;
    logic             load;
    logic             accept;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_byte;

    assign accept = tx_valid && tx_ready;

    // Look one byte ahead so the next data byte is ready when the current one is taken
    assign rd_idx = (state == DATA) ? idx + IDX_W'(1) : '0;

    pmc_snapshot_reg #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_snap (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .din     (counters_in),
        .rd_idx  (rd_idx),
        .rd_byte (rd_byte)
    );

    // State and registered outputs; reset abandons any partial frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            chk         <= 8'h00;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            chk         <= chk_nxt;
            tx_valid    <= tx_valid_nxt;
            tx_data     <= tx_data_nxt;
            busy        <= busy_nxt;
            frame_done  <= done_nxt;
            frame_count <= count_nxt;
        end
    end

    // Next-state, checksum and next output values; everything holds unless a byte is accepted
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        chk_nxt      = chk;
        tx_valid_nxt = tx_valid;
        tx_data_nxt  = tx_data;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        count_nxt    = frame_count;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (snapshot_req) begin
                    load         = 1'b1;
                    state_nxt    = HDR;
                    busy_nxt     = 1'b1;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = HEADER_BYTE;
                end
            end
            HDR: begin
                if (accept) begin
                    state_nxt   = LEN;
                    tx_data_nxt = LEN_BYTE;
                end
            end
            LEN: begin
                if (accept) begin
                    state_nxt   = DATA;
                    idx_nxt     = '0;
                    chk_nxt     = LEN_BYTE;
                    tx_data_nxt = rd_byte;
                end
            end
            DATA: begin
                if (accept) begin
                    chk_nxt = chk ^ tx_data;
                    if (idx == LAST_IDX) begin
                        state_nxt   = CHK;
                        tx_data_nxt = chk ^ tx_data;
                    end else begin
                        idx_nxt     = idx + IDX_W'(1);
                        tx_data_nxt = rd_byte;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_nxt    = IDLE;
                    tx_valid_nxt = 1'b0;
                    tx_data_nxt  = 8'h00;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b1;
                    count_nxt    = frame_count + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
